// File: rtl/sram_port_responder.sv
// Memory-side responder: serves a write channel and a read channel onto one
// single-port synchronous SRAM through a small posted-write buffer.
module sram_port_responder #(
  parameter int ADDR_W     = 26,
  parameter int DATA_W     = 32,
  parameter int WBUF_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wvalid,
  output logic              wready,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              rvalid,
  output logic              rready,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              wbuf_empty
);

  localparam int PW = $clog2(WBUF_DEPTH);
  localparam int CW = PW + 1;

  logic [ADDR_W-1:0]     buf_addr [WBUF_DEPTH];
  logic [DATA_W-1:0]     buf_data [WBUF_DEPTH];
  logic [WBUF_DEPTH-1:0] buf_valid;
  logic [PW-1:0]         wptr, rptr;
  logic [CW-1:0]         count;
  logic                  rd_pend;
  logic [DATA_W-1:0]     rdata_hold;

  logic full, hazard, rd_acc, drain, enq;

  assign full = (count == CW'(WBUF_DEPTH));

  // Reads must not overtake any buffered write to the same word, not only the head.
  always_comb begin
    hazard = 1'b0;
    for (int unsigned i = 0; i < WBUF_DEPTH; i++) begin
      if (buf_valid[PW'(i)] && (buf_addr[PW'(i)] == raddr)) hazard = 1'b1;
    end
  end

  assign wready     = !rst && !full;
  assign rready     = !rst && !full && !hazard;
  assign rd_acc     = rvalid && rready;
  assign drain      = !rst && !rd_acc && (count != '0);
  assign enq        = wvalid && wready;
  assign wbuf_empty = (count == '0) || rst;

  always_comb begin
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (rd_acc) begin
      mem_en   = 1'b1;
      mem_addr = raddr;
    end else if (drain) begin
      mem_en    = 1'b1;
      mem_we    = 1'b1;
      mem_addr  = buf_addr[rptr];
      mem_wdata = buf_data[rptr];
    end
  end

  always_ff @(posedge clk) begin
    if (enq) begin
      buf_addr[wptr] <= waddr;
      buf_data[wptr] <= wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr      <= '0;
      rptr      <= '0;
      count     <= '0;
      buf_valid <= '0;
    end else begin
      // Slots differ whenever both happen: drain needs count>0, enqueue needs count<DEPTH.
      if (drain) begin
        buf_valid[rptr] <= 1'b0;
        rptr            <= rptr + PW'(1);
      end
      if (enq) begin
        buf_valid[wptr] <= 1'b1;
        wptr            <= wptr + PW'(1);
      end
      case ({enq, drain})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_pend    <= 1'b0;
      rdata_hold <= '0;
    end else begin
      rd_pend <= rd_acc;
      if (rd_pend) rdata_hold <= mem_rdata;
    end
  end

  assign rdata = rst ? '0 : (rd_pend ? mem_rdata : rdata_hold);

endmodule

// File: tb/tb_sram_port_responder.sv
// Bench for sram_port_responder: queue/array model checked every cycle, plus
// directed scenarios with literal expectations.
module tb_sram_port_responder;

  localparam int AW = 26;
  localparam int DW = 32;
  localparam int D  = 4;

  logic          clk = 1'b0;
  logic          rst, wvalid, rvalid;
  logic [AW-1:0] waddr, raddr;
  logic [DW-1:0] wdata;
  logic          wready, rready, mem_en, mem_we, wbuf_empty;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata, rdata;

  sram_port_responder #(.ADDR_W(AW), .DATA_W(DW), .WBUF_DEPTH(D)) dut (
    .clk(clk), .rst(rst),
    .wvalid(wvalid), .wready(wready), .waddr(waddr), .wdata(wdata),
    .rvalid(rvalid), .rready(rready), .raddr(raddr), .rdata(rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .wbuf_empty(wbuf_empty)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", nm, act, req, $time);
    end
  endtask

  // SRAM macro behaviour (environment, not the reference model).
  logic [DW-1:0] sram [logic [AW-1:0]];
  logic          s_en, s_we;
  logic [AW-1:0] s_addr;
  logic [DW-1:0] s_wdata;

  always @(posedge clk) begin
    if (s_en && s_we) sram[s_addr] = s_wdata;
    if (s_en && !s_we) mem_rdata <= sram.exists(s_addr) ? sram[s_addr] : '0;
    else               mem_rdata <= $urandom;
  end

  // Reference model: committed memory plus an ordered list of posted writes.
  typedef struct { logic [AW-1:0] a; logic [DW-1:0] d; } ent_t;
  ent_t          q[$];
  logic [DW-1:0] m_mem [logic [AW-1:0]];
  logic [DW-1:0] m_rdata = '0;

  function automatic logic [DW-1:0] mget(input logic [AW-1:0] a);
    return m_mem.exists(a) ? m_mem[a] : '0;
  endfunction

  always @(negedge clk) begin
    logic full, hz, rd, dr;
    s_en = mem_en; s_we = mem_we; s_addr = mem_addr; s_wdata = mem_wdata;
    if (rst) begin
      chk("rst_wready", wready, 0);
      chk("rst_rready", rready, 0);
      chk("rst_mem_en", mem_en, 0);
      chk("rst_mem_we", mem_we, 0);
      chk("rst_mem_addr", mem_addr, 0);
      chk("rst_mem_wdata", mem_wdata, 0);
      chk("rst_rdata", rdata, 0);
      chk("rst_wbuf_empty", wbuf_empty, 1);
      q.delete();
      m_rdata = '0;
    end else begin
      full = (q.size() == D);
      hz = 1'b0;
      foreach (q[i]) if (q[i].a == raddr) hz = 1'b1;
      rd = rvalid && !full && !hz;
      dr = !rd && (q.size() != 0);
      chk("wready", wready, !full);
      chk("rready", rready, !full && !hz);
      chk("mem_en", mem_en, rd || dr);
      chk("mem_we", mem_we, dr);
      chk("mem_addr", mem_addr, rd ? raddr : (dr ? q[0].a : '0));
      chk("mem_wdata", mem_wdata, dr ? q[0].d : '0);
      chk("rdata", rdata, m_rdata);
      chk("wbuf_empty", wbuf_empty, q.size() == 0);
      if (rd) m_rdata = mget(raddr);
      if (dr) begin
        m_mem[q[0].a] = q[0].d;
        void'(q.pop_front());
      end
      if (wvalid && !full) q.push_back('{a: waddr, d: wdata});
    end
  end

  task automatic step(input logic r, input logic wv, input logic [AW-1:0] wa,
                      input logic [DW-1:0] wd, input logic rv, input logic [AW-1:0] ra);
    @(posedge clk);
    #1;
    rst = r; wvalid = wv; waddr = wa; wdata = wd; rvalid = rv; raddr = ra;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, '0, '0, 0, '0);
  endtask

  task automatic preload(input logic [AW-1:0] a, input logic [DW-1:0] d);
    sram[a]  = d;
    m_mem[a] = d;
  endtask

  initial begin
    rst = 1; wvalid = 0; rvalid = 0; waddr = '0; wdata = '0; raddr = '0;
    s_en = 0; s_we = 0; s_addr = '0; s_wdata = '0; mem_rdata = '0;

    // Reset then idle
    for (int i = 0; i < 3; i++) step(1, 1, 26'h5, 32'h5, 1, 26'h5);
    chk("lit_rst_empty", wbuf_empty, 1);
    chk("lit_rst_mem_en", mem_en, 0);
    idle(1);
    chk("lit_rel_wready", wready, 1);
    chk("lit_rel_rready", rready, 1);
    chk("lit_rel_mem_en", mem_en, 0);

    // Write then hazarded read of the same word
    step(0, 1, 26'h10, 32'hDEADBEEF, 0, '0);
    step(0, 0, '0, '0, 1, 26'h10);
    chk("lit_hz_rready", rready, 0);
    chk("lit_hz_drain", mem_we, 1);
    step(0, 0, '0, '0, 1, 26'h10);
    chk("lit_hz_rready2", rready, 1);
    idle(1);
    chk("lit_hz_rdata", rdata, 32'hDEADBEEF);

    // Fill the buffer while reads keep winning the port
    for (int i = 0; i < 4; i++) step(0, 1, AW'(i), 32'h100 + i, 1, 26'h100);
    step(0, 1, 26'h4, 32'h104, 1, 26'h100);
    chk("lit_full_wready", wready, 0);
    chk("lit_full_rready", rready, 0);
    chk("lit_full_drain_addr", mem_addr, 0);
    chk("lit_full_we", mem_we, 1);
    step(0, 1, 26'h4, 32'h104, 1, 26'h100);
    chk("lit_fifth_wready", wready, 1);
    idle(10);
    chk("lit_fill_empty", wbuf_empty, 1);

    // Same-cycle read and write to one word
    preload(26'h20, 32'h1);
    step(0, 1, 26'h20, 32'h2, 1, 26'h20);
    idle(1);
    chk("lit_rw_old", rdata, 32'h1);
    idle(2);
    step(0, 0, '0, '0, 1, 26'h20);
    idle(1);
    chk("lit_rw_new", rdata, 32'h2);

    // Back-to-back reads
    preload(26'h0, 32'hA); preload(26'h1, 32'hB); preload(26'h2, 32'hC);
    step(0, 0, '0, '0, 1, 26'h0);
    step(0, 0, '0, '0, 1, 26'h1);
    chk("lit_b2b_a", rdata, 32'hA);
    step(0, 0, '0, '0, 1, 26'h2);
    chk("lit_b2b_b", rdata, 32'hB);
    idle(1);
    chk("lit_b2b_c", rdata, 32'hC);
    idle(1);
    chk("lit_b2b_hold", rdata, 32'hC);

    // Reset while writes are still buffered
    preload(26'h30, 32'h55); preload(26'h31, 32'h56); preload(26'h32, 32'h57);
    for (int i = 0; i < 3; i++) step(0, 1, 26'h30 + AW'(i), 32'h99, 1, 26'h200);
    step(1, 0, '0, '0, 0, '0);
    for (int i = 0; i < 3; i++) begin
      idle(1);
      chk("lit_mid_empty", wbuf_empty, 1);
      chk("lit_mid_no_we", mem_we, 0);
    end
    step(0, 0, '0, '0, 1, 26'h31);
    idle(1);
    chk("lit_mid_old", rdata, 32'h56);

    // Interleaved traffic over a few words
    for (int i = 0; i < 40; i++)
      step(0, (i % 3) != 2, AW'(i % 4), 32'h11 * i, (i % 2) == 1, AW'((i + 1) % 4));
    idle(8);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
